tlc: RTL and testbench
======================

// Module: tlc
// PURPOSE
//  4-way (roads A-D) adaptive traffic-light controller with per-lane density sensors.
//  Grants green to the densest road, preempted by special-service (emergency) requests.
//  Red-light violations on any red road raise a camera trigger.
//  Top-level intersection block; outputs drive lamp drivers and a camera unit.
// PARAMETERS
//  GREEN_MIN   4  minimum green dwell in cycles before a density-based handover (>=1)
//  YELLOW_CYC  2  yellow duration in cycles (>=1)
// PORTS
//  clock       in   1   single system clock, rising edge
//  clear       in   1   reset; synchronous and active-high
//  a1,a2,a3    in   1   road A lane occupancy sensors (b*, c*, d* likewise for B, C, D)
//  rc1..rc4    in   1   red-crossing detector for road A..D
//  ss1..ss4    in   1   special-service request for road A..D; ss1 highest priority
//  ID          out  12  lamps {R,Y,G} per road: [11:9]=A [8:6]=B [5:3]=C [2:0]=D
//  camera      out  1   registered violation flag
//  state       out  6   current FSM state, one-hot
//  next_state  out  6   combinational next state, one-hot
//  maxoutput   out  3   densest road: 0=none, 1=A, 2=B, 3=C, 4=D
// BEHAVIOUR
//  Density: dA=a1+a2+a3 (0..3), same for dB, dC, dD. All combinational.
//  maxoutput = road with the largest density; ties go to the lowest letter.
//  maxoutput = 0 when all densities are 0.
//  ssel = highest-priority active ss road (1..4), 0 if none.
//  States: IDLE=6'b000001, GA=000010, GB=000100, GC=001000, GD=010000, YEL=100000.
//  tgt = ssel if ssel!=0, else maxoutput. tgt 0 -> IDLE, 1..4 -> GA..GD.
//  IDLE: go to tgt state; stay in IDLE if tgt=0.
//  Gx on arrival: cnt is cleared to 0, then increments (saturates) each cycle in Gx.
//  Gx, ssel!=0 and ssel!=x: go to YEL immediately (preemption ignores GREEN_MIN).
//  Gx, ssel==x: stay in Gx.
//  Gx, ssel==0, cnt>=GREEN_MIN-1 and maxoutput!=x: go to YEL.
//    This includes maxoutput==0; otherwise stay in Gx.
//  YEL: last-green road (register lastg) shows yellow for YELLOW_CYC cycles.
//    On exit, go to tgt as evaluated in the exit cycle; tgt==lastg is allowed.
//  ID decode from the registered state: non-green roads are R (100).
//    Gx: road x = 001. YEL: road lastg = 010.
//    IDLE: all roads 100 (12'h924).
//  camera <= OR over i of (rc_i & road i lamp == 100), latched each clock (1-cycle latency).
//    Yellow or green is not a violation.
//  clear=1 at an edge: state=IDLE, cnt=0, lastg=0, camera=0.
//    ID=12'h924 from the following cycle; clear dominates all inputs.
//    Clear mid-green or mid-yellow is abandoned immediately, with no yellow phase.
//  next_state is the pure function above.
//    With clear asserted, next_state must still show the value the FSM would take without clear.
//  Simultaneous ss on several roads: the lowest index wins.
//  ss dropping mid-green: normal density rules resume; cnt keeps counting.
// STRUCTURE
//  Package tlc_pkg: state one-hot localparams, lamp codes LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001.
//  Package tlc_pkg also holds the road index codes.
//  Sub-module tlc_density_arb: 12 sensors -> maxoutput (combinational, with tie rule).
//  Top module holds the FSM, dwell counter, lastg, lamp decode and camera register.
// TESTING
//  clear, then a1=b1=c1=d1=1 -> maxoutput=1.
//    Next edge: state=GA, ID=12'b001_100_100_100.
//  In GA with b1=b2=1 (dB=2): hold GA for GREEN_MIN cycles, then YEL.
//    YEL: ID[11:9]=010 for 2 cycles, then GB with ID[8:6]=001.
//  In GB, assert ss4 -> next edge YEL (preempt), then GD.
//    ss1=ss3=1 together -> route to GA.
//  In GC, rc1=1 -> camera=1 one cycle later; rc3=1 alone -> camera stays 0.
//  All sensors, ss and rc at 0 -> maxoutput=0.
//    After GREEN_MIN: YEL, then IDLE with ID=12'h924.
//  Assert clear mid-YEL -> next edge state=IDLE, camera=0, cnt=0.
//    All sensors high -> maxoutput=1 (tie rule).

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and helpers for the four-way adaptive traffic-light controller.
// States are one-hot; road codes are 0 (none) and 1..4 for roads A..D.
package tlc_pkg;

   typedef enum logic [5:0] {
      S_IDLE = 6'b000001,
      S_GA   = 6'b000010,
      S_GB   = 6'b000100,
      S_GC   = 6'b001000,
      S_GD   = 6'b010000,
      S_YEL  = 6'b100000
   } tlc_state_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [2:0] ROAD_NONE = 3'd0;
   localparam logic [2:0] ROAD_A    = 3'd1;
   localparam logic [2:0] ROAD_B    = 3'd2;
   localparam logic [2:0] ROAD_C    = 3'd3;
   localparam logic [2:0] ROAD_D    = 3'd4;

   localparam logic [11:0] ID_ALL_RED = 12'h924;
   localparam int          CNT_W      = 8;

   function automatic logic [1:0] density(input logic [2:0] lanes);
      density = {1'b0, lanes[2]} + {1'b0, lanes[1]} + {1'b0, lanes[0]};
   endfunction

   function automatic tlc_state_e green_state(input logic [2:0] road);
      case (road)
         ROAD_A:  green_state = S_GA;
         ROAD_B:  green_state = S_GB;
         ROAD_C:  green_state = S_GC;
         ROAD_D:  green_state = S_GD;
         default: green_state = S_IDLE;
      endcase
   endfunction

   // Road currently holding green, ROAD_NONE outside the green states.
   function automatic logic [2:0] green_road(input tlc_state_e st);
      case (st)
         S_GA:    green_road = ROAD_A;
         S_GB:    green_road = ROAD_B;
         S_GC:    green_road = ROAD_C;
         S_GD:    green_road = ROAD_D;
         default: green_road = ROAD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tlc_density_arb.sv
// Picks the densest road from twelve lane sensors {A1..A3,B1..B3,C1..C3,D1..D3}.
// Ties resolve to the lowest letter; an empty intersection yields ROAD_NONE.
module tlc_density_arb
   import tlc_pkg::*;
(
   input  logic [11:0] sensors_i,
   output logic [2:0]  max_road_o
);

   logic [1:0] dens_s;
   logic [1:0] best_dens_s;
   logic [2:0] best_road_s;

   // Strict greater-than while scanning A..D keeps the earliest road on ties.
   always_comb begin
      dens_s      = 2'd0;
      best_dens_s = 2'd0;
      best_road_s = ROAD_NONE;
      for (int r = 0; r < 4; r++) begin
         dens_s = density(sensors_i[11-3*r -: 3]);
         if (dens_s > best_dens_s) begin
            best_dens_s = dens_s;
            best_road_s = 3'(r + 1);
         end else begin
            best_dens_s = best_dens_s;
         end
      end
      max_road_o = best_road_s;
   end

endmodule

// File: rtl/tlc.sv
// Four-way adaptive traffic-light controller: density-driven green, emergency
// preemption, yellow handover, lamp decode and red-light camera trigger.
module tlc
   import tlc_pkg::*;
#(
   parameter int GREEN_MIN  = 4,
   parameter int YELLOW_CYC = 2
)
(
   input  logic        clock,
   input  logic        clear,
   input  logic        a1,
   input  logic        a2,
   input  logic        a3,
   input  logic        b1,
   input  logic        b2,
   input  logic        b3,
   input  logic        c1,
   input  logic        c2,
   input  logic        c3,
   input  logic        d1,
   input  logic        d2,
   input  logic        d3,
   input  logic        rc1,
   input  logic        rc2,
   input  logic        rc3,
   input  logic        rc4,
   input  logic        ss1,
   input  logic        ss2,
   input  logic        ss3,
   input  logic        ss4,
   output logic [11:0] ID,
   output logic        camera,
   output logic [5:0]  state,
   output logic [5:0]  next_state,
   output logic [2:0]  maxoutput
);

   localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic [11:0]      sensors_s;
   logic [3:0]       ss_s;
   logic [3:0]       rc_s;
   logic [2:0]       max_road_s;
   logic [2:0]       ssel_s;
   logic [2:0]       tgt_s;
   logic [2:0]       cur_road_s;
   logic [2:0]       next_green_s;
   logic [2:0]       lamp_s;

   tlc_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       lastg_q, lastg_d;
   logic [11:0]      id_q, id_d;
   logic             camera_q, camera_d;

   assign sensors_s = {a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3};
   assign ss_s      = {ss4, ss3, ss2, ss1};
   assign rc_s      = {rc4, rc3, rc2, rc1};

   tlc_density_arb u_arb (
      .sensors_i  (sensors_s),
      .max_road_o (max_road_s)
   );

   // Lowest-index special-service request wins.
   always_comb begin
      ssel_s = ROAD_NONE;
      if (ss_s[0]) begin
         ssel_s = ROAD_A;
      end else if (ss_s[1]) begin
         ssel_s = ROAD_B;
      end else if (ss_s[2]) begin
         ssel_s = ROAD_C;
      end else if (ss_s[3]) begin
         ssel_s = ROAD_D;
      end else begin
         ssel_s = ROAD_NONE;
      end
      tgt_s = (ssel_s != ROAD_NONE) ? ssel_s : max_road_s;
   end

   assign cur_road_s = green_road(state_q);

   // Next-state function; deliberately independent of clear.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            state_d = green_state(tgt_s);
         end
         S_GA, S_GB, S_GC, S_GD: begin
            if (ssel_s != ROAD_NONE) begin
               if (ssel_s != cur_road_s) begin
                  state_d = S_YEL;
               end else begin
                  state_d = state_q;
               end
            end else if ((cnt_q >= GREEN_LAST) && (max_road_s != cur_road_s)) begin
               state_d = S_YEL;
            end else begin
               state_d = state_q;
            end
         end
         S_YEL: begin
            if (cnt_q >= YEL_LAST) begin
               state_d = green_state(tgt_s);
            end else begin
               state_d = S_YEL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Dwell counter restarts on every state change; lastg remembers who goes yellow.
   always_comb begin
      cnt_d   = cnt_q;
      lastg_d = lastg_q;
      if (state_d != state_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      if ((cur_road_s != ROAD_NONE) && (state_d == S_YEL)) begin
         lastg_d = cur_road_s;
      end else begin
         lastg_d = lastg_q;
      end
   end

   assign next_green_s = green_road(state_d);

   // Lamp pattern is built from the next state so ID is a clean register.
   always_comb begin
      id_d   = ID_ALL_RED;
      lamp_s = LAMP_R;
      for (int r = 0; r < 4; r++) begin
         if (next_green_s == 3'(r + 1)) begin
            lamp_s = LAMP_G;
         end else if ((state_d == S_YEL) && (lastg_d == 3'(r + 1))) begin
            lamp_s = LAMP_Y;
         end else begin
            lamp_s = LAMP_R;
         end
         id_d[11-3*r -: 3] = lamp_s;
      end
   end

   // A crossing only counts against a road that is showing red right now.
   always_comb begin
      camera_d = 1'b0;
      for (int r = 0; r < 4; r++) begin
         if (rc_s[r] && (id_q[11-3*r -: 3] == LAMP_R)) begin
            camera_d = 1'b1;
         end else begin
            camera_d = camera_d;
         end
      end
   end

   // State, dwell, lamps and camera registers with dominant synchronous clear.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         lastg_q  <= ROAD_NONE;
         id_q     <= ID_ALL_RED;
         camera_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lastg_q  <= lastg_d;
         id_q     <= id_d;
         camera_q <= camera_d;
      end
   end

   assign ID         = id_q;
   assign camera     = camera_q;
   assign state      = state_q;
   assign next_state = state_d;
   assign maxoutput  = max_road_s;

endmodule

// File: tb/tb_tlc.sv
// Self-checking bench for tlc: arbiter vector table, directed sequences and
// randomized traffic compared against a phase/road reference model.
module tb_tlc;

   localparam int GREEN_MIN  = 4;
   localparam int YELLOW_CYC = 2;

   logic        clock = 1'b0;
   logic        clear;
   logic [11:0] sens;
   logic [3:0]  ss;
   logic [3:0]  rc;
   logic [11:0] ID;
   logic        camera;
   logic [5:0]  state;
   logic [5:0]  next_state;
   logic [2:0]  maxoutput;

   int n_checks = 0;
   int n_fail   = 0;

   // model: phase 0=idle 1=green 2=yellow
   int   m_phase, m_road, m_lastg, m_cnt;
   logic m_cam;

   always #5 clock = ~clock;

   tlc #(.GREEN_MIN(GREEN_MIN), .YELLOW_CYC(YELLOW_CYC)) dut (
      .clock(clock), .clear(clear),
      .a1(sens[11]), .a2(sens[10]), .a3(sens[9]),
      .b1(sens[8]),  .b2(sens[7]),  .b3(sens[6]),
      .c1(sens[5]),  .c2(sens[4]),  .c3(sens[3]),
      .d1(sens[2]),  .d2(sens[1]),  .d3(sens[0]),
      .rc1(rc[0]), .rc2(rc[1]), .rc3(rc[2]), .rc4(rc[3]),
      .ss1(ss[0]), .ss2(ss[1]), .ss3(ss[2]), .ss4(ss[3]),
      .ID(ID), .camera(camera), .state(state),
      .next_state(next_state), .maxoutput(maxoutput)
   );

   typedef struct {
      logic [11:0] sens;
      logic [3:0]  ss;
      logic [2:0]  exp_max;
      logic [5:0]  exp_next;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dens(input int r);
      int c = 0;
      for (int k = 0; k < 3; k++) if (sens[11 - 3*(r-1) - k]) c++;
      return c;
   endfunction

   function automatic int maxroad();
      int best = 0;
      int bd = 0;
      for (int r = 1; r <= 4; r++) begin
         if (dens(r) > bd) begin
            bd = dens(r);
            best = r;
         end
      end
      return best;
   endfunction

   function automatic int sselm();
      for (int r = 1; r <= 4; r++) if (ss[r-1]) return r;
      return 0;
   endfunction

   function automatic logic [5:0] onehot(input int ph, input int road);
      if (ph == 0) return 6'b000001;
      if (ph == 2) return 6'b100000;
      return 6'(1 << road);
   endfunction

   function automatic logic [2:0] lamp(input int ph, input int road, input int lastg, input int r);
      if (ph == 1 && road == r) return 3'b001;
      if (ph == 2 && lastg == r) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [11:0] idexp(input int ph, input int road, input int lastg);
      logic [11:0] id;
      id = 12'd0;
      for (int r = 1; r <= 4; r++) id[11 - 3*(r-1) -: 3] = lamp(ph, road, lastg, r);
      return id;
   endfunction

   task automatic model_next(output int nph, output int nroad);
      int s;
      int mx;
      int t;
      s  = sselm();
      mx = maxroad();
      t  = (s != 0) ? s : mx;
      nph = m_phase;
      nroad = m_road;
      if (m_phase == 0) begin
         nph = (t == 0) ? 0 : 1;
         nroad = t;
      end else if (m_phase == 1) begin
         if (s != 0 && s != m_road) begin
            nph = 2; nroad = 0;
         end else if (s == m_road) begin
            nph = 1;
         end else if (m_cnt >= GREEN_MIN - 1 && mx != m_road) begin
            nph = 2; nroad = 0;
         end
      end else begin
         if (m_cnt >= YELLOW_CYC - 1) begin
            nph = (t == 0) ? 0 : 1;
            nroad = t;
         end
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_road = 0; m_lastg = 0; m_cnt = 0; m_cam = 1'b0;
   endtask

   task automatic step();
      int   nph;
      int   nroad;
      logic cam_n;
      @(negedge clock);
      model_next(nph, nroad);
      chk("maxoutput", 32'(maxoutput), 32'(maxroad()));
      chk("next_state", 32'(next_state), 32'(onehot(nph, nroad)));
      cam_n = 1'b0;
      for (int r = 1; r <= 4; r++)
         if (rc[r-1] && lamp(m_phase, m_road, m_lastg, r) == 3'b100) cam_n = 1'b1;
      @(posedge clock);
      if (clear) begin
         model_reset();
      end else begin
         if (nph != m_phase || nroad != m_road) m_cnt = 0;
         else m_cnt++;
         if (m_phase == 1 && nph == 2) m_lastg = m_road;
         m_phase = nph;
         m_road  = nroad;
         m_cam   = cam_n;
      end
      #1;
      chk("state", 32'(state), 32'(onehot(m_phase, m_road)));
      chk("ID", 32'(ID), 32'(idexp(m_phase, m_road, m_lastg)));
      chk("camera", 32'(camera), 32'(m_cam));
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{12'h000,             4'b0000, 3'd0, 6'b000001};
      tbl[1] = '{12'hFFF,             4'b0000, 3'd1, 6'b000010};
      tbl[2] = '{12'b000_000_000_100, 4'b0000, 3'd4, 6'b010000};
      tbl[3] = '{12'b000_110_110_000, 4'b0000, 3'd2, 6'b000100};
      tbl[4] = '{12'b100_000_000_111, 4'b0000, 3'd4, 6'b010000};
      tbl[5] = '{12'b000_000_001_000, 4'b0000, 3'd3, 6'b001000};
      tbl[6] = '{12'b011_011_111_010, 4'b0000, 3'd3, 6'b001000};
      tbl[7] = '{12'hFFF,             4'b1010, 3'd1, 6'b000100};
      tbl[8] = '{12'h000,             4'b1000, 3'd0, 6'b010000};
      tbl[9] = '{12'b100_110_000_000, 4'b0101, 3'd2, 6'b000010};

      clear = 1'b1; sens = 12'h000; ss = 4'b0000; rc = 4'b0000;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      chk("reset_state", 32'(state), 32'h01);
      chk("reset_ID", 32'(ID), 32'h924);
      chk("reset_camera", 32'(camera), 32'h0);

      // Arbiter table while held in clear; next_state must ignore clear.
      foreach (tbl[i]) begin
         sens = tbl[i].sens;
         ss   = tbl[i].ss;
         step();
         chk("table_max", 32'(maxoutput), 32'(tbl[i].exp_max));
         chk("table_next", 32'(next_state), 32'(tbl[i].exp_next));
      end

      // Tie on all four roads -> A.
      clear = 1'b0; ss = 4'b0000; sens = 12'b100_100_100_100;
      step();
      chk("seq_GA", 32'(state), 32'h02);
      chk("seq_GA_ID", 32'(ID), 32'(12'b001_100_100_100));

      // B denser: GA held GREEN_MIN cycles, two yellow cycles, then GB.
      sens = 12'b000_110_000_000;
      repeat (3) step();
      chk("seq_GA_hold", 32'(state), 32'h02);
      step();
      chk("seq_YEL1", 32'(state), 32'h20);
      chk("seq_YEL1_ID", 32'(ID), 32'(12'b010_100_100_100));
      step();
      chk("seq_YEL2", 32'(state), 32'h20);
      step();
      chk("seq_GB", 32'(state), 32'h04);
      chk("seq_GB_ID", 32'(ID), 32'(12'b100_001_100_100));

      // Preempt by ss4, then ss1+ss3 together route to A.
      ss = 4'b1000;
      step();
      chk("seq_pre_YEL", 32'(state), 32'h20);
      chk("seq_pre_YEL_ID", 32'(ID), 32'(12'b100_010_100_100));
      repeat (2) step();
      chk("seq_GD", 32'(state), 32'h10);
      ss = 4'b0101;
      repeat (3) step();
      chk("seq_ss13_GA", 32'(state), 32'h02);

      // Camera in GC: red A crossing triggers, green C crossing does not.
      ss = 4'b0100;
      repeat (3) step();
      chk("seq_GC", 32'(state), 32'h08);
      rc = 4'b0001;
      step();
      chk("seq_cam_A", 32'(camera), 32'h1);
      rc = 4'b0100;
      step();
      chk("seq_cam_C", 32'(camera), 32'h0);

      // Empty intersection: yellow then idle.
      sens = 12'h000; ss = 4'b0000; rc = 4'b0000;
      repeat (4) step();
      chk("seq_idle", 32'(state), 32'h01);
      chk("seq_idle_ID", 32'(ID), 32'h924);
      chk("seq_idle_max", 32'(maxoutput), 32'h0);

      // Clear in the middle of yellow wins over a pending violation.
      sens = 12'hFFF;
      step();
      ss = 4'b0010;
      step();
      chk("seq_clr_pre", 32'(state), 32'h20);
      rc = 4'b0010; clear = 1'b1;
      step();
      chk("seq_clr_state", 32'(state), 32'h01);
      chk("seq_clr_camera", 32'(camera), 32'h0);
      chk("seq_clr_ID", 32'(ID), 32'h924);
      chk("seq_clr_max", 32'(maxoutput), 32'h1);
      clear = 1'b0; ss = 4'b0000; rc = 4'b0000; sens = 12'h000;
      step();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) sens = 12'($urandom);
         ss    = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
         rc    = 4'($urandom);
         clear = ($urandom_range(60) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
